// File: rtl/alpha_cpu_pkg.sv
// alpha_cpu_pkg: shared EX-stage encodings (ALU select width, MDU ops and MDU states)
package alpha_cpu_pkg;
  localparam int ALU_SEL_W = 4;
  typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} mdu_state_e;
  function automatic logic mdu_is_mul(input logic [1:0] op);
    return op inside {MDU_MULT, MDU_MULTU};
  endfunction
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return op inside {MDU_MULT, MDU_DIV};
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on a {rem, quo} pair
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   div_i,
  output logic [2*WIDTH-1:0] rq_o
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh   = rq_i[2*WIDTH-1:WIDTH-1];
    diff = sh - {1'b0, div_i};
    rq_o = diff[WIDTH] ? {sh[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit producing the HI/LO pair for the EX stage.
// Define MDU_FAST_MUL_EN to finish multiplies in a single BUSY cycle with a full-width multiplier.
module ex_mul_div_unit
  import alpha_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dv_q, dv_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] abs_a, abs_b, rem_fix, quo_fix;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] div_rq, mul_rq, mul_raw, mul_res;
  logic sgn, last, fast;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rq_i ({rem_q, quo_q}),
    .div_i(dv_q),
    .rq_o (div_rq)
  );

`ifdef MDU_FAST_MUL_EN
  assign fast    = mul_q;
  assign mul_raw = {{WIDTH{1'b0}}, dv_q} * {{WIDTH{1'b0}}, quo_q};
`else
  assign fast    = 1'b0;
  assign mul_raw = {rem_q, quo_q};
`endif

  assign last = fast | (cnt_q == CW'(WIDTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operands are held as magnitudes; signs are reapplied when results are captured.
  always_comb begin
    sgn     = mdu_is_signed(op);
    abs_a   = (sgn & a[WIDTH-1]) ? -a : a;
    abs_b   = (sgn & b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dv_q} : '0);
    mul_rq  = {sum, quo_q[WIDTH-1:1]};
    mul_res = neg_q ? -mul_raw : mul_raw;
    rem_fix = rneg_q ? -rem_q : rem_q;
    quo_fix = dz_q ? {WIDTH{1'b1}} : neg_q ? -quo_q : quo_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dv_d    = dv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      mul_d  = mdu_is_mul(op);
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = mul_d ? abs_b : abs_a;
      dv_d   = mul_d ? abs_a : abs_b;
      neg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d = sgn & a[WIDTH-1];
      dz_d   = ~mul_d & ~|b;
    end else if (state_q == BUSY && !last) begin
      cnt_d          = cnt_q + 1'b1;
      {rem_d, quo_d} = mul_q ? mul_rq : div_rq;
    end
    if (state_q == BUSY && state_d == DONE) {hi_d, lo_d} = mul_q ? mul_res : {rem_fix, quo_fix};
  end

  always_comb begin
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    div_by_zero = done & dz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dv_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dv_q    <= dv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
